// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe
// Simple dual-port RAM on one clock. It has one byte-enabled write port and one
// fully pipelined read port with a valid strobe and a collision flag.
// After reset, a hardware sweep zeroes every entry before Ready rises.
// Optional feature macro: RAM_PARITY_EN. It adds per-byte even parity, the
// Par_inj input and the Parity_err output.
module dual_port_ram_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic                Clock,
    input  logic                Resetn,
    output logic                Ready,
    input  logic                Wr_en,
    input  logic [ADDR_W-1:0]   Wr_addr,
    input  logic [DATA_W-1:0]   Wr_data,
    input  logic [DATA_W/8-1:0] Wr_be,
    input  logic                Rd_en,
    input  logic [ADDR_W-1:0]   Rd_addr,
    output logic [DATA_W-1:0]   Rd_data,
    output logic                Rd_valid,
    output logic                Collision
`ifdef RAM_PARITY_EN
    ,
    input  logic                Par_inj,
    output logic                Parity_err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] initCnt_q, initCnt_d;
    logic              readyInt;
    logic              sweepActive;

    logic [DATA_W-1:0] memData_q [DEPTH];

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [NB-1:0]     memBe;

    logic              rdAccept;
    logic              collide;
    logic [NB-1:0]     bypassBe;
    logic [DATA_W-1:0] rdWord;

    logic [RD_LAT-1:0] pipeValid_q;
    logic [RD_LAT-1:0] pipeColl_q;
    logic [DATA_W-1:0] pipeData_q [RD_LAT];

    // Sweep/run state and sweep address; reset re-arms the sweep from address 0
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_SWEEP;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    // Step through every address once, then move to run on the last entry
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        case (state_q)
            ST_SWEEP: begin
                initCnt_d = initCnt_q + 1'b1;
                if (initCnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_SWEEP;
            end
        endcase
    end

    // Ready only once the sweep has cleared every entry
    always_comb begin
        readyInt    = (state_q == ST_RUN);
        sweepActive = (state_q == ST_SWEEP);
        Ready       = readyInt;
    end

    // Select the array write source: sweep zeroing, or a user write once ready
    always_comb begin
        memWe    = 1'b0;
        memAddr  = Wr_addr;
        memWdata = Wr_data;
        memBe    = Wr_be;
        if (sweepActive) begin
            memWe    = 1'b1;
            memAddr  = initCnt_q;
            memWdata = '0;
            memBe    = '1;
        end else if (Wr_en) begin
            memWe = 1'b1;
        end
    end

    // Byte-granular array update; the array itself has no reset, the sweep clears it
    always_ff @(posedge Clock) begin
        if (memWe) begin
            for (int b = 0; b < NB; b++) begin
                if (memBe[b]) begin
                    memData_q[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
                end
            end
        end
    end

    // Capture the read word at acceptance, merging same-cycle write bytes when bypassing
    always_comb begin
        rdAccept = readyInt & Rd_en;
        collide  = rdAccept & Wr_en & (Wr_addr == Rd_addr);
        bypassBe = '0;
        if (collide && (BYPASS != 0)) begin
            bypassBe = Wr_be;
        end
        rdWord = memData_q[Rd_addr];
        for (int b = 0; b < NB; b++) begin
            if (bypassBe[b]) begin
                rdWord[8*b +: 8] = Wr_data[8*b +: 8];
            end
        end
    end

    // Read pipeline. Each stage's data only moves with a valid, so the last stage
    // holds its word between pulses. Reset drops everything in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pipeValid_q <= '0;
            pipeColl_q  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipeData_q[k] <= '0;
            end
        end else begin
            pipeValid_q[0] <= rdAccept;
            pipeColl_q[0]  <= collide;
            if (rdAccept) begin
                pipeData_q[0] <= rdWord;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipeValid_q[k] <= pipeValid_q[k-1];
                pipeColl_q[k]  <= pipeColl_q[k-1];
                if (pipeValid_q[k-1]) begin
                    pipeData_q[k] <= pipeData_q[k-1];
                end
            end
        end
    end

    assign Rd_valid  = pipeValid_q[RD_LAT-1];
    assign Collision = pipeColl_q[RD_LAT-1];
    assign Rd_data   = pipeData_q[RD_LAT-1];

`ifdef RAM_PARITY_EN
    logic [NB-1:0]     memPar_q [DEPTH];
    logic [NB-1:0]     memParW;
    logic [NB-1:0]     rdParStored;
    logic [DATA_W-1:0] rdOld;
    logic              rdPerr;
    logic [RD_LAT-1:0] pipePerr_q;

    // Even parity per written byte; injection inverts it, except while sweeping
    always_comb begin
        memParW = '0;
        for (int b = 0; b < NB; b++) begin
            memParW[b] = (^memWdata[8*b +: 8]) ^ (Par_inj & ~sweepActive);
        end
    end

    // Parity bits follow the same byte enables as the data array
    always_ff @(posedge Clock) begin
        if (memWe) begin
            for (int b = 0; b < NB; b++) begin
                if (memBe[b]) begin
                    memPar_q[memAddr][b] <= memParW[b];
                end
            end
        end
    end

    // Check stored bytes only; bypassed bytes come straight from Wr_data and are clean
    always_comb begin
        rdPerr      = 1'b0;
        rdParStored = memPar_q[Rd_addr];
        rdOld       = memData_q[Rd_addr];
        for (int b = 0; b < NB; b++) begin
            if (!bypassBe[b]) begin
                rdPerr = rdPerr | ((^rdOld[8*b +: 8]) ^ rdParStored[b]);
            end
        end
    end

    // Carry the parity verdict alongside its read through the pipeline
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pipePerr_q <= '0;
        end else begin
            pipePerr_q[0] <= rdAccept & rdPerr;
            for (int k = 1; k < RD_LAT; k++) begin
                pipePerr_q[k] <= pipePerr_q[k-1];
            end
        end
    end

    assign Parity_err = pipePerr_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Testbench for dual_port_ram_pipe.
// Two instances share all inputs: one with the new-data collision policy and
// one with the old-data policy. Both use a read latency of 2.
module tb_dual_port_ram_pipe;

    logic        clock;
    logic        resetn;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    logic        rdEn;
    logic [3:0]  rdAddr;

    logic        readyB, rdValidB, collB;
    logic [31:0] rdDataB;
    logic        readyO, rdValidO, collO;
    logic [31:0] rdDataO;
`ifdef RAM_PARITY_EN
    logic        parInj;
    logic        parErrB, parErrO;
`endif

    int total = 0;
    int bad   = 0;

    dual_port_ram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .BYPASS(1)) dutB (
        .Clock(clock), .Resetn(resetn), .Ready(readyB),
        .Wr_en(wrEn), .Wr_addr(wrAddr), .Wr_data(wrData), .Wr_be(wrBe),
        .Rd_en(rdEn), .Rd_addr(rdAddr),
        .Rd_data(rdDataB), .Rd_valid(rdValidB), .Collision(collB)
`ifdef RAM_PARITY_EN
        , .Par_inj(parInj), .Parity_err(parErrB)
`endif
    );

    dual_port_ram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .BYPASS(0)) dutO (
        .Clock(clock), .Resetn(resetn), .Ready(readyO),
        .Wr_en(wrEn), .Wr_addr(wrAddr), .Wr_data(wrData), .Wr_be(wrBe),
        .Rd_en(rdEn), .Rd_addr(rdAddr),
        .Rd_data(rdDataO), .Rd_valid(rdValidO), .Collision(collO)
`ifdef RAM_PARITY_EN
        , .Par_inj(parInj), .Parity_err(parErrO)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at limit, expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Drive one write for a single cycle; inputs change on the falling edge
    task automatic applyWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        wrEn = 1'b1; wrAddr = a; wrData = d; wrBe = be;
        @(negedge clock);
        wrEn = 1'b0; wrBe = 4'b0000;
    endtask

    // Issue one read and sample both instances two edges later
    task automatic applyRead(input logic [3:0] a,
                             output logic [31:0] dB, output logic vB, output logic cB,
                             output logic [31:0] dO, output logic vO, output logic cO);
        @(negedge clock);
        rdEn = 1'b1; rdAddr = a;
        @(negedge clock);
        rdEn = 1'b0;
        @(negedge clock);
        dB = rdDataB; vB = rdValidB; cB = collB;
        dO = rdDataO; vO = rdValidO; cO = collO;
    endtask

    // Reset values while Resetn is held low
    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (readyB !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %0b expected 0", readyB); end
        total++; if (rdValidB !== 1'b0 || rdValidO !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b/%0b expected 0/0", rdValidB, rdValidO); end
        total++; if (collB !== 1'b0) begin bad++; $display("[TB] FAIL reset_coll: got %0b expected 0", collB); end
        total++; if (rdDataB !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00000000", rdDataB); end
`ifdef RAM_PARITY_EN
        total++; if (parErrB !== 1'b0) begin bad++; $display("[TB] FAIL reset_parerr: got %0b expected 0", parErrB); end
`endif
    endtask

    // Sweep length, requests ignored during the sweep, then 16 back-to-back zero reads
    task automatic test_init_sweep();
        int cycles;
        int pulses;
        logic seenValid;
        cycles = 0; pulses = 0; seenValid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        while (cycles < 40 && readyB !== 1'b1) begin
            if (cycles == 10) begin
                wrEn = 1'b1; wrAddr = 4'd0; wrData = 32'hFFFFFFFF; wrBe = 4'b1111;
                rdEn = 1'b1; rdAddr = 4'd0;
            end else begin
                wrEn = 1'b0; wrBe = 4'b0000; rdEn = 1'b0;
            end
            @(negedge clock);
            cycles++;
            if (rdValidB === 1'b1 || rdValidO === 1'b1) seenValid = 1'b1;
        end
        wrEn = 1'b0; wrBe = 4'b0000; rdEn = 1'b0;
        total++; if (cycles != 16) begin bad++; $display("[TB] FAIL sweep_len: got %0d cycles expected 16", cycles); end
        total++; if (seenValid !== 1'b0) begin bad++; $display("[TB] FAIL sweep_no_valid: got %0b expected 0", seenValid); end
        total++; if (readyO !== 1'b1) begin bad++; $display("[TB] FAIL sweep_ready_o: got %0b expected 1", readyO); end
        for (int c = 0; c < 18; c++) begin
            if (c >= 2) begin
                total++;
                if (rdValidB !== 1'b1 || rdDataB !== 32'h0) begin
                    bad++; $display("[TB] FAIL sweep_read_%0d: got v=%0b d=%h expected v=1 d=00000000", c - 2, rdValidB, rdDataB);
                end
            end
            if (rdValidB === 1'b1) pulses++;
            rdEn = (c < 16); rdAddr = c[3:0];
            @(negedge clock);
        end
        total++; if (rdValidB !== 1'b0) begin bad++; $display("[TB] FAIL sweep_read_end: got %0b expected 0", rdValidB); end
        total++; if (pulses != 16) begin bad++; $display("[TB] FAIL sweep_pulses: got %0d expected 16", pulses); end
    endtask

    // Byte enables merge into the stored word; all-zero enables leave it alone
    task automatic test_byte_enables();
        logic [31:0] dB, dO;
        logic vB, cB, vO, cO;
        applyWrite(4'd3, 32'hAABBCCDD, 4'b1111);
        applyWrite(4'd3, 32'h11223344, 4'b0101);
        applyRead(4'd3, dB, vB, cB, dO, vO, cO);
        total++; if (vB !== 1'b1 || dB !== 32'hAA22CC44) begin bad++; $display("[TB] FAIL be_merge: got v=%0b d=%h expected v=1 d=AA22CC44", vB, dB); end
        applyWrite(4'd3, 32'hFFFFFFFF, 4'b0000);
        applyRead(4'd3, dB, vB, cB, dO, vO, cO);
        total++; if (dB !== 32'hAA22CC44 || cB !== 1'b0) begin bad++; $display("[TB] FAIL be_zero: got d=%h c=%0b expected d=AA22CC44 c=0", dB, cB); end
    endtask

    // Four consecutive reads give four consecutive pulses two edges later, then data holds
    task automatic test_latency();
        logic [31:0] expData;
        logic expValid;
        applyWrite(4'd0, 32'h10, 4'b1111);
        applyWrite(4'd1, 32'h20, 4'b1111);
        applyWrite(4'd2, 32'h30, 4'b1111);
        applyWrite(4'd3, 32'h40, 4'b1111);
        for (int c = 0; c < 7; c++) begin
            expValid = (c >= 2 && c < 6);
            expData  = (c >= 2 && c < 6) ? 32'((c - 1) * 16) : ((c == 6) ? 32'h40 : rdDataB);
            if (c >= 1) begin
                total++;
                if (rdValidB !== expValid || (c >= 2 && rdDataB !== expData)) begin
                    bad++; $display("[TB] FAIL lat_cycle_%0d: got v=%0b d=%h expected v=%0b d=%h", c, rdValidB, rdDataB, expValid, expData);
                end
            end
            rdEn = (c < 4); rdAddr = c[3:0];
            @(negedge clock);
        end
        rdEn = 1'b0;
    endtask

    // Same-address collision under both policies, a different-address pair, and write-then-read
    task automatic test_collision();
        logic [31:0] dB, dO;
        logic vB, cB, vO, cO;
        applyWrite(4'd5, 32'h0000FFFF, 4'b1111);
        @(negedge clock);
        wrEn = 1'b1; wrAddr = 4'd5; wrData = 32'h12345678; wrBe = 4'b1100;
        rdEn = 1'b1; rdAddr = 4'd5;
        @(negedge clock);
        wrEn = 1'b0; wrBe = 4'b0000; rdEn = 1'b0;
        @(negedge clock);
        total++; if (rdValidB !== 1'b1 || rdDataB !== 32'h1234FFFF || collB !== 1'b1) begin
            bad++; $display("[TB] FAIL coll_new: got v=%0b d=%h c=%0b expected v=1 d=1234FFFF c=1", rdValidB, rdDataB, collB); end
        total++; if (rdValidO !== 1'b1 || rdDataO !== 32'h0000FFFF || collO !== 1'b1) begin
            bad++; $display("[TB] FAIL coll_old: got v=%0b d=%h c=%0b expected v=1 d=0000FFFF c=1", rdValidO, rdDataO, collO); end
        @(negedge clock);
        total++; if (collB !== 1'b0 || rdDataB !== 32'h1234FFFF) begin
            bad++; $display("[TB] FAIL coll_pulse: got c=%0b d=%h expected c=0 d=1234FFFF", collB, rdDataB); end
        applyRead(4'd5, dB, vB, cB, dO, vO, cO);
        total++; if (dO !== 32'h1234FFFF || cO !== 1'b0 || vO !== 1'b1) begin
            bad++; $display("[TB] FAIL coll_after: got v=%0b d=%h c=%0b expected v=1 d=1234FFFF c=0", vO, dO, cO); end
        @(negedge clock);
        wrEn = 1'b1; wrAddr = 4'd6; wrData = 32'hCAFEF00D; wrBe = 4'b1111;
        rdEn = 1'b1; rdAddr = 4'd5;
        @(negedge clock);
        wrEn = 1'b0; wrBe = 4'b0000;
        rdAddr = 4'd6;
        @(negedge clock);
        rdEn = 1'b0;
        total++; if (rdDataB !== 32'h1234FFFF || collB !== 1'b0 || rdValidB !== 1'b1) begin
            bad++; $display("[TB] FAIL diff_addr: got v=%0b d=%h c=%0b expected v=1 d=1234FFFF c=0", rdValidB, rdDataB, collB); end
        @(negedge clock);
        total++; if (rdDataB !== 32'hCAFEF00D || rdValidB !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_then_rd: got v=%0b d=%h expected v=1 d=CAFEF00D", rdValidB, rdDataB); end
    endtask

    // Reset drops an in-flight read and restarts a partial sweep from scratch
    task automatic test_reset_mid();
        logic [31:0] dB, dO;
        logic vB, cB, vO, cO;
        int cycles;
        logic seenValid;
        seenValid = 1'b0;
        @(negedge clock);
        rdEn = 1'b1; rdAddr = 4'd3;
        @(negedge clock);
        rdEn = 1'b0;
        resetn = 1'b0;
        #1;
        total++; if (readyB !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got %0b expected 0", readyB); end
        repeat (3) begin
            @(negedge clock);
            if (rdValidB === 1'b1 || rdValidO === 1'b1) seenValid = 1'b1;
        end
        total++; if (seenValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_dropped: got valid=%0b expected 0", seenValid); end
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        cycles = 0;
        while (cycles < 40 && readyB !== 1'b1) begin
            @(negedge clock);
            cycles++;
        end
        total++; if (cycles != 16) begin bad++; $display("[TB] FAIL mid_sweep_len: got %0d cycles expected 16", cycles); end
        applyRead(4'd3, dB, vB, cB, dO, vO, cO);
        total++; if (vB !== 1'b1 || dB !== 32'h0) begin bad++; $display("[TB] FAIL mid_cleared: got v=%0b d=%h expected v=1 d=00000000", vB, dB); end
    endtask

`ifdef RAM_PARITY_EN
    // Injected parity flags on readback; a clean rewrite clears it
    task automatic test_parity();
        logic [31:0] dB, dO;
        logic vB, cB, vO, cO;
        parInj = 1'b1;
        applyWrite(4'd7, 32'hDEADBEEF, 4'b1111);
        parInj = 1'b0;
        @(negedge clock);
        rdEn = 1'b1; rdAddr = 4'd7;
        @(negedge clock);
        rdEn = 1'b0;
        @(negedge clock);
        total++; if (parErrB !== 1'b1 || rdValidB !== 1'b1 || parErrO !== 1'b1) begin
            bad++; $display("[TB] FAIL par_inj: got perr=%0b/%0b v=%0b expected 1/1 v=1", parErrB, parErrO, rdValidB); end
        applyWrite(4'd7, 32'hDEADBEEF, 4'b1111);
        applyRead(4'd7, dB, vB, cB, dO, vO, cO);
        total++; if (parErrB !== 1'b0 || vB !== 1'b1 || dB !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL par_clean: got perr=%0b v=%0b d=%h expected 0 1 DEADBEEF", parErrB, vB, dB); end
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        resetn = 1'b0;
        wrEn = 1'b0; wrAddr = 4'd0; wrData = 32'h0; wrBe = 4'b0000;
        rdEn = 1'b0; rdAddr = 4'd0;
`ifdef RAM_PARITY_EN
        parInj = 1'b0;
`endif
        test_reset();
        test_init_sweep();
        test_byte_enables();
        test_latency();
        test_collision();
        test_reset_mid();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
